// File: rtl/muldiv_unit.sv
// muldiv_unit: sequential 32-bit MULT/MULTU/DIV/DIVU unit writing HI/LO.
// FSM IDLE -> PREP -> RUN (WIDTH iterations) -> FIX -> DONE.
// Fixed latency: 35 cycles from start to done for every op.
// Optional feature macro: MULDIV_DIV_EN.
//   Defined:   all four ops are supported.
//   Undefined: the divide datapath is removed. Ops 10/11 keep the full
//              timing but return hi = lo = 0 and never raise div_by_zero.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;          // raw dividend/multiplicand, kept for div-by-zero
  logic [WIDTH-1:0]   b_q, b_d;          // raw b until PREP, |b| afterwards
  logic [2*WIDTH-1:0] acc_q, acc_d;      // {hi half, lo half} working register
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q_q, neg_q_d;  // product / quotient sign
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  // Operand magnitudes; signed ops have op[0] == 0
  logic             is_signed;
  logic [WIDTH-1:0] a_abs, b_abs;
  assign is_signed = ~op_q[0];
  assign a_abs = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_abs = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

  // Multiply step: conditional add into the upper half, then shift right
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next, prod;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign prod     = neg_q_q ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
  // Restoring divide step: shift {rem, quo} left, trial-subtract the divisor
  logic               neg_r_q, neg_r_d;  // remainder sign
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo, rem;
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
  assign quo = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_q_d = neg_q_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
`ifdef MULDIV_DIV_EN
    neg_r_d = neg_r_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          dbz_d   = 1'b0;
          state_d = PREP;
        end else begin
          state_d = IDLE;
        end
      end
      PREP: begin
        acc_d   = {{WIDTH{1'b0}}, a_abs};
        b_d     = b_abs;
        neg_q_d = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
`ifdef MULDIV_DIV_EN
        neg_r_d = is_signed & a_q[WIDTH-1];
`endif
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
`ifdef MULDIV_DIV_EN
        acc_d = op_q[1] ? div_next : mul_next;
`else
        acc_d = mul_next;
`endif
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        if (!op_q[1]) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else begin
`ifdef MULDIV_DIV_EN
          if (b_q == '0) begin
            hi_d  = a_q;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            hi_d = rem;
            lo_d = quo;
          end
`else
          hi_d = '0;
          lo_d = '0;
`endif
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == PREP) || (state_d == RUN) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  // State and output registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_r_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q_q <= neg_q_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
`ifdef MULDIV_DIV_EN
      neg_r_q <= neg_r_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule
